// File: rtl/cnn_layer_sequencer_if.sv
// rtl/cnn_layer_sequencer_if.sv - control/status bundle between the layer sequencer and its environment
//
// Purpose: groups the inference control inputs, the per-layer start/done handshake,
// the weight/bias arbiter selects and the status outputs of cnn_layer_sequencer.
// Ports (signals):
//   cnn_start, abort, timeout_limit : run control, driven by the master
//   layer_done                      : per-layer done pulses, driven by the master
//   layer_start                     : per-layer start pulses, driven by the slave
//   weight_sel, bias_sel            : arbiter selects, driven by the slave
//   cur_layer, busy, cnn_done,
//   timeout_err                     : status, driven by the slave
// Modports: master = environment side, slave = sequencer side.
interface cnn_layer_sequencer_if #(
  parameter int NUM_LAYERS = 7,
  parameter int SEL_W      = 5,
  parameter int TIMEOUT_W  = 20
);
  logic                  cnn_start;
  logic                  abort;
  logic [TIMEOUT_W-1:0]  timeout_limit;
  logic [NUM_LAYERS-1:0] layer_done;
  logic [NUM_LAYERS-1:0] layer_start;
  logic [SEL_W-1:0]      weight_sel;
  logic [SEL_W-1:0]      bias_sel;
  logic [SEL_W-1:0]      cur_layer;
  logic                  busy;
  logic                  cnn_done;
  logic                  timeout_err;

  modport master (
    output cnn_start, abort, timeout_limit, layer_done,
    input  layer_start, weight_sel, bias_sel, cur_layer, busy, cnn_done, timeout_err
  );

  modport slave (
    input  cnn_start, abort, timeout_limit, layer_done,
    output layer_start, weight_sel, bias_sel, cur_layer, busy, cnn_done, timeout_err
  );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - in-order CNN layer scheduler with weight/bias arbiter select and watchdog
//
// Purpose: launches layers 1..NUM_LAYERS one at a time, waits for each layer's done,
// steers the weight/bias arbiter to the active layer (0 for layers without weights),
// and flags a layer that stays in WAIT for timeout_limit cycles.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   bus  : cnn_layer_sequencer_if.slave (control inputs, layer handshake, selects, status)
module cnn_layer_sequencer #(
  parameter int                    NUM_LAYERS = 7,
  parameter logic [NUM_LAYERS-1:0] WB_MASK    = 7'b1011011,
  parameter int                    SEL_W      = 5,
  parameter int                    TIMEOUT_W  = 20
) (
  input logic                  clk,
  input logic                  rst,
  cnn_layer_sequencer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH, S_ERR} state_t;

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      cur_q, cur_d, nxt_layer;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [TIMEOUT_W-1:0]  wdog_q, wdog_d, wdog_inc;
  logic [NUM_LAYERS-1:0] start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  terr_q, terr_d;
  logic                  done_hit, timed_out;

  // One-hot start vector for a 1-based layer index; out-of-range gives 0.
  function automatic logic [NUM_LAYERS-1:0] layer_bit(input logic [SEL_W-1:0] idx);
    logic [NUM_LAYERS-1:0] v;
    v = '0;
    for (int i = 1; i <= NUM_LAYERS; i++)
      if (idx == SEL_W'(i)) v[i-1] = 1'b1;
    return v;
  endfunction

  // Arbiter select: the layer index if that layer reads weights/bias, else 0 (parked).
  function automatic logic [SEL_W-1:0] wb_sel_of(input logic [SEL_W-1:0] idx);
    logic [SEL_W-1:0] s;
    s = '0;
    for (int i = 1; i <= NUM_LAYERS; i++)
      if (idx == SEL_W'(i) && WB_MASK[i-1]) s = idx;
    return s;
  endfunction

  assign nxt_layer = cur_q + SEL_W'(1);
  // Saturating so a disabled watchdog never wraps into a false match later.
  assign wdog_inc  = (&wdog_q) ? wdog_q : wdog_q + TIMEOUT_W'(1);
  // Only the active layer's done bit counts; strays from other layers are dropped.
  assign done_hit  = |(bus.layer_done & layer_bit(cur_q));
  assign timed_out = (bus.timeout_limit != '0) && (wdog_inc >= bus.timeout_limit);

  always_comb begin
    state_d = state_q;
    cur_d   = '0;
    sel_d   = '0;
    wdog_d  = '0;
    start_d = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    terr_d  = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (bus.cnn_start) begin
            state_d = S_LAUNCH;
            cur_d   = SEL_W'(1);
            start_d = layer_bit(SEL_W'(1));
            sel_d   = wb_sel_of(SEL_W'(1));
            busy_d  = 1'b1;
          end else if (state_q == S_ERR) begin
            terr_d = 1'b1;
          end
        end
        S_LAUNCH: begin
          state_d = S_WAIT;
          cur_d   = cur_q;
          sel_d   = sel_q;
          busy_d  = 1'b1;
        end
        S_WAIT: begin
          // Done is checked before the watchdog so a done on the limit cycle wins.
          if (done_hit && cur_q < SEL_W'(NUM_LAYERS)) begin
            state_d = S_LAUNCH;
            cur_d   = nxt_layer;
            start_d = layer_bit(nxt_layer);
            sel_d   = wb_sel_of(nxt_layer);
            busy_d  = 1'b1;
          end else if (done_hit) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
          end else if (timed_out) begin
            state_d = S_ERR;
            terr_d  = 1'b1;
          end else begin
            cur_d  = cur_q;
            sel_d  = sel_q;
            wdog_d = wdog_inc;
            busy_d = 1'b1;
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      sel_q   <= '0;
      wdog_q  <= '0;
      start_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      sel_q   <= sel_d;
      wdog_q  <= wdog_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.layer_start = start_q;
  assign bus.weight_sel  = sel_q;
  assign bus.bias_sel    = sel_q;
  assign bus.cur_layer   = cur_q;
  assign bus.busy        = busy_q;
  assign bus.cnn_done    = done_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb/tb_cnn_layer_sequencer.sv - randomized self-checking bench for cnn_layer_sequencer
module tb_cnn_layer_sequencer;
  localparam int              NL = 7;
  localparam logic [NL-1:0]   WB = 7'b1011011;

  // One clock cycle: inputs sampled at the edge and the outputs expected after it.
  typedef struct {
    logic          start;
    logic          abort;
    logic [NL-1:0] done;
    logic [NL-1:0] ls;
    logic [4:0]    sel;
    logic [4:0]    cur;
    logic          busy;
    logic          cd;
    logic          te;
  } step_t;

  step_t q[$];
  int    dly[1:NL];
  int    limit;
  int    n_vec;
  int    n_bad;
  int    cur_step;
  logic  clk;
  logic  rst;

  cnn_layer_sequencer_if bus();

  cnn_layer_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", tag, cur_step, got, want);
    end
  endtask

  function automatic logic [NL-1:0] noise(input int layer);
    logic [NL-1:0] m;
    m = NL'($urandom);
    if (layer > 0) m[layer-1] = 1'b0;
    return m;
  endfunction

  function automatic step_t zero_step(input logic st, input logic ab, input logic [NL-1:0] dn,
                                      input logic te);
    step_t s;
    s.start = st; s.abort = ab; s.done = dn;
    s.ls = '0; s.sel = '0; s.cur = '0; s.busy = 1'b0; s.cd = 1'b0; s.te = te;
    return s;
  endfunction

  // Layer L running: pulse=1 is the launch cycle, pulse=0 a waiting cycle.
  function automatic step_t run_step(input int layer, input logic pulse, input logic st,
                                     input logic [NL-1:0] dn);
    step_t s;
    s = zero_step(st, 1'b0, dn, 1'b0);
    s.ls   = pulse ? NL'(1 << (layer - 1)) : '0;
    s.sel  = WB[layer-1] ? 5'(layer) : 5'd0;
    s.cur  = 5'(layer);
    s.busy = 1'b1;
    return s;
  endfunction

  task automatic build_idle(input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(zero_step(1'b0, 1'b0, noise(0), 1'b0));
  endtask

  // restart: 0 = abort out of ERR, 1 = restart with cnn_start, 2 = random choice.
  task automatic build_run(input int abort_at, input int restart);
    bit ended;
    step_t s;
    q.delete();
    q.push_back(run_step(1, 1'b1, 1'b1, noise(0)));
    ended = 0;
    for (int l = 1; l <= NL && !ended; l++) begin
      // Sampled during LAUNCH: any done here, even the layer's own, is ignored.
      q.push_back(run_step(l, 1'b0, 1'($urandom), noise(0)));
      for (int j = 1; j <= 200; j++) begin
        if (j == dly[l]) begin
          if (l < NL) q.push_back(run_step(l + 1, 1'b1, 1'($urandom), noise(l) | NL'(1 << (l - 1))));
          else begin
            s = zero_step(1'($urandom), 1'b0, noise(l) | NL'(1 << (l - 1)), 1'b0);
            s.cd = 1'b1;
            q.push_back(s);
          end
          break;
        end else if (limit != 0 && j == limit) begin
          q.push_back(zero_step(1'($urandom), 1'b0, noise(l), 1'b1));
          ended = 1;
          break;
        end else begin
          q.push_back(run_step(l, 1'b0, 1'($urandom), noise(l)));
        end
      end
    end
    if (!ended) begin
      q.push_back(zero_step(1'($urandom), 1'b0, noise(0), 1'b0));
    end else begin
      for (int k = 0; k < int'($urandom_range(1, 3)); k++)
        q.push_back(zero_step(1'b0, 1'b0, noise(0), 1'b1));
      if (restart == 1 || (restart == 2 && $urandom_range(0, 1) == 1))
        q.push_back(run_step(1, 1'b1, 1'b1, noise(0)));
      q.push_back(zero_step(1'($urandom), 1'b1, noise(0), 1'b0));
    end
    if (abort_at >= 0 && abort_at < q.size()) begin
      q[abort_at] = zero_step(q[abort_at].start, 1'b1, q[abort_at].done, 1'b0);
      while (q.size() > abort_at + 1) void'(q.pop_back());
    end
    q.push_back(zero_step(1'b0, 1'b0, noise(0), 1'b0));
    q.push_back(zero_step(1'b0, 1'b0, noise(0), 1'b0));
  endtask

  task automatic check_outputs(input step_t s);
    check("layer_start", 32'(bus.layer_start), 32'(s.ls));
    check("weight_sel",  32'(bus.weight_sel),  32'(s.sel));
    check("bias_sel",    32'(bus.bias_sel),    32'(s.sel));
    check("cur_layer",   32'(bus.cur_layer),   32'(s.cur));
    check("busy",        32'(bus.busy),        32'(s.busy));
    check("cnn_done",    32'(bus.cnn_done),    32'(s.cd));
    check("timeout_err", 32'(bus.timeout_err), 32'(s.te));
  endtask

  task automatic apply_steps(input int n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      @(negedge clk);
      bus.cnn_start     = q[i].start;
      bus.abort         = q[i].abort;
      bus.layer_done    = q[i].done;
      bus.timeout_limit = 20'(limit);
      @(posedge clk);
      #1;
      check_outputs(q[i]);
      cur_step++;
    end
  endtask

  task automatic set_dly(input int d);
    for (int l = 1; l <= NL; l++) dly[l] = d;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; cur_step = 0; limit = 0;
    rst = 1'b0;
    bus.cnn_start = 1'b0; bus.abort = 1'b0; bus.layer_done = '0; bus.timeout_limit = '0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(zero_step(1'b0, 1'b0, '0, 1'b0));
    @(negedge clk);
    rst = 1'b1;

    // Full run, done on the 3rd WAIT cycle of every layer, watchdog off.
    limit = 0; set_dly(3);
    build_run(-1, 0); apply_steps(q.size());

    // Layer 2 hangs with limit 10, then restart from ERR.
    limit = 10; set_dly(3); dly[2] = 99;
    build_run(-1, 1); apply_steps(q.size());

    // Done on exactly the limit-th WAIT cycle wins over the watchdog.
    limit = 4; set_dly(2); dly[1] = 4;
    build_run(-1, 0); apply_steps(q.size());

    // Abort while layer 4 waits (each layer spans 3 steps with 2-cycle waits).
    limit = 0; set_dly(2);
    build_run(11, 0); apply_steps(q.size());

    // cnn_start together with abort in IDLE stays idle.
    build_run(0, 0); apply_steps(q.size());

    // Asynchronous reset in the middle of layer 2's WAIT.
    limit = 0; set_dly(1); dly[2] = 5;
    build_run(-1, 0); apply_steps(5);
    #3 rst = 1'b0;
    #1 check_outputs(zero_step(1'b0, 1'b0, '0, 1'b0));
    @(negedge clk);
    bus.cnn_start = 1'b0; bus.abort = 1'b0; bus.layer_done = '0;
    @(negedge clk);
    rst = 1'b1;
    build_idle(3); apply_steps(q.size());

    // Randomized scenarios.
    for (int n = 0; n < 40; n++) begin
      for (int l = 1; l <= NL; l++) dly[l] = $urandom_range(1, 6);
      limit = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 8));
      if (limit != 0 && $urandom_range(0, 3) == 0) dly[$urandom_range(1, NL)] = 99;
      build_run(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1, 2);
      apply_steps(q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
